// File: rtl/uart_lite_pkg.sv
// -----------------------------------------------------------------------------
// uart_lite_pkg
// Shared definitions for the uart_lite_periph memory-mapped UART:
//   - register offsets decoded from addr[3:2]
//   - STATUS register bit positions
//   - TX/RX frame FSM state type
//   - minimum legal baud divider and the clamp helper applied on writes
// -----------------------------------------------------------------------------
package uart_lite_pkg;

  // Register offsets (addr[3:2])
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_TX_BUSY      = 2;
  localparam int ST_RX_VALID     = 3;
  localparam int ST_TX_OVERFLOW  = 4;
  localparam int ST_RX_OVERRUN   = 5;
  localparam int ST_RX_FRAME_ERR = 6;
  localparam int ST_COUNT_LSB    = 8;

  // Smallest divider that still leaves a usable RX half-period sample point
  localparam logic [15:0] MIN_BAUD_DIV = 16'd3;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  function automatic logic [15:0] clamp_baud(input logic [15:0] value);
    return (value < MIN_BAUD_DIV) ? MIN_BAUD_DIV : value;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through FIFO holding bytes waiting for the
// serializer. A push while full is accepted only if a pop happens in the same
// cycle (the pop frees the slot first).
// Ports:
//   clk, rst    clock, synchronous active-low reset
//   push, wdata write request and byte
//   pop         read request (ignored when empty)
//   rdata       head-of-queue byte (valid while !empty)
//   full, empty occupancy flags
//   count       number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import uart_lite_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, so clearing the data would cost logic for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_lite_periph.sv
// -----------------------------------------------------------------------------
// uart_lite_periph
// Memory-mapped 8N1 UART: TX FIFO + serializer, RX holding register, sticky
// error flags and a programmable baud divider (bit period = baud_div+1 clocks).
// Read data is registered: a read strobe in cycle N returns data in N+1.
// Build option: define UART_RX_EN to include the receiver; without it uart_rx
// is ignored, RXDATA reads 0 and STATUS bits 3, 5, 6 read 0.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   uart_mem_write_en     register write strobe
//   uart_mem_read_en      register read strobe
//   uart_mem_strobe       byte-lane enables
//   uart_mem_addr_o       byte address, only [3:2] decoded
//   uart_mem_write_data   write data
//   uart_mem_read_data    registered read data
//   uart_tx               serial out, idle high
//   uart_rx               serial in, asynchronous
// -----------------------------------------------------------------------------
module uart_lite_periph
  import uart_lite_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int TX_FIFO_DEPTH    = 8,
  parameter int DEFAULT_BAUD_DIV = 433
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_mem_write_en,
  input  logic                  uart_mem_read_en,
  input  logic [3:0]            uart_mem_strobe,
  input  logic [DATA_WIDTH-1:0] uart_mem_addr_o,
  input  logic [DATA_WIDTH-1:0] uart_mem_write_data,
  output logic [DATA_WIDTH-1:0] uart_mem_read_data,
  output logic                  uart_tx,
  input  logic                  uart_rx
);

  localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [1:0]  addr_sel;
  logic        wr_txdata;
  logic        wr_baud;
  logic        wr_status;
  logic [15:0] baud_wdata;
  logic [15:0] baud_div;

  assign addr_sel  = uart_mem_addr_o[3:2];
  assign wr_txdata = uart_mem_write_en && (addr_sel == REG_TXDATA) && uart_mem_strobe[0];
  assign wr_status = uart_mem_write_en && (addr_sel == REG_STATUS) && uart_mem_strobe[0];
  assign wr_baud   = uart_mem_write_en && (addr_sel == REG_BAUD) && (uart_mem_strobe[1:0] != 2'b00);

  // Lanes not enabled keep their current byte
  assign baud_wdata = {uart_mem_strobe[1] ? uart_mem_write_data[15:8] : baud_div[15:8],
                       uart_mem_strobe[0] ? uart_mem_write_data[7:0]  : baud_div[7:0]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic          tx_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          tx_overflow;

  uart_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .wdata (uart_mem_write_data[7:0]),
    .pop   (tx_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // TX serializer
  // ---------------------------------------------------------------------------
  uart_state_t tx_state;
  uart_state_t tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;

  assign tx_bit_end = (tx_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) tx_state <= UART_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      UART_IDLE:  if (!fifo_empty) tx_next = UART_START;
      UART_START: if (tx_bit_end) tx_next = UART_DATA;
      UART_DATA:  if (tx_bit_end && (tx_bit == 3'd7)) tx_next = UART_STOP;
      // Chain straight into the next start bit so back-to-back bytes have no gap
      UART_STOP:  if (tx_bit_end) tx_next = fifo_empty ? UART_IDLE : UART_START;
      default:    tx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = 1'b0;
    uart_tx = 1'b1;
    case (tx_state)
      UART_IDLE:  tx_pop = !fifo_empty;
      UART_START: uart_tx = 1'b0;
      UART_DATA:  uart_tx = tx_shift[0];
      UART_STOP:  tx_pop = tx_bit_end && !fifo_empty;
      default:    ;
    endcase
  end

  // Bit timer reloads from baud_div at every boundary, so divider writes
  // apply from the next bit onward.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_pop) begin
      tx_shift <= fifo_rdata;
      tx_cnt   <= baud_div;
      tx_bit   <= '0;
    end else if (tx_state != UART_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt <= baud_div;
        if (tx_state == UART_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;

`ifdef UART_RX_EN
  logic [1:0]  rx_sync;
  logic        rx_s;
  logic        rx_prev;
  uart_state_t rx_state;
  uart_state_t rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick;
  logic        rx_start;
  logic        rx_sample;
  logic        rx_done;
  logic        rd_rxdata;

  assign rx_s      = rx_sync[1];
  assign rx_tick   = (rx_cnt == '0);
  assign rd_rxdata = uart_mem_read_en && (addr_sel == REG_RXDATA);

  always_ff @(posedge clk) begin
    if (!rst) rx_state <= UART_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      UART_IDLE:  if (rx_prev && !rx_s) rx_next = UART_START;
      // A start bit that reads high at its midpoint was a glitch
      UART_START: if (rx_tick) rx_next = rx_s ? UART_IDLE : UART_DATA;
      UART_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = UART_STOP;
      UART_STOP:  if (rx_tick) rx_next = UART_IDLE;
      default:    rx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    rx_start  = 1'b0;
    rx_sample = 1'b0;
    rx_done   = 1'b0;
    case (rx_state)
      UART_IDLE: rx_start  = rx_prev && !rx_s;
      UART_DATA: rx_sample = rx_tick;
      UART_STOP: rx_done   = rx_tick;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
      if (rx_start) begin
        // First sample lands mid start bit; later ones a full period apart
        rx_cnt <= baud_div >> 1;
        rx_bit <= '0;
      end else if (rx_state != UART_IDLE) begin
        if (rx_tick) begin
          rx_cnt <= baud_div;
          if (rx_sample) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
          end
        end else begin
          rx_cnt <= rx_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      // A byte load beats a same-cycle RXDATA read clearing rx_valid
      if (rx_done && rx_s && !rx_valid) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_rxdata) begin
        rx_valid <= 1'b0;
      end

      if (rx_done && rx_s && rx_valid)
        rx_overrun <= 1'b1;
      else if (wr_status && uart_mem_write_data[ST_RX_OVERRUN])
        rx_overrun <= 1'b0;

      if (rx_done && !rx_s)
        rx_frame_err <= 1'b1;
      else if (wr_status && uart_mem_write_data[ST_RX_FRAME_ERR])
        rx_frame_err <= 1'b0;
    end
  end
`else
  logic unused_rx;
  assign unused_rx    = uart_rx;
  assign rx_data      = '0;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Registers and read path
  // ---------------------------------------------------------------------------
  logic [15:0]           status;
  logic [DATA_WIDTH-1:0] read_mux;

  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = fifo_full;
    status[ST_TX_EMPTY]     = fifo_empty;
    status[ST_TX_BUSY]      = !fifo_empty || (tx_state != UART_IDLE);
    status[ST_RX_VALID]     = rx_valid;
    status[ST_TX_OVERFLOW]  = tx_overflow;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
    status[15:ST_COUNT_LSB] = 8'(fifo_count);
  end

  always_comb begin
    read_mux = '0;
    case (addr_sel)
      REG_RXDATA: read_mux[7:0]  = rx_data;
      REG_STATUS: read_mux[15:0] = status;
      REG_BAUD:   read_mux[15:0] = baud_div;
      default:    ;
    endcase
  end

  // NOTE: non-blocking assignments here mean a same-cycle read samples the
  // pre-write register values, which is exactly the required read/write order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      uart_mem_read_data <= '0;
      baud_div           <= 16'(DEFAULT_BAUD_DIV);
      tx_overflow        <= 1'b0;
    end else begin
      if (uart_mem_read_en) uart_mem_read_data <= read_mux;
      if (wr_baud) baud_div <= clamp_baud(baud_wdata);
      // Push into a full FIFO with no simultaneous pop loses the byte
      if (wr_txdata && fifo_full && !tx_pop)
        tx_overflow <= 1'b1;
      else if (wr_status && uart_mem_write_data[ST_TX_OVERFLOW])
        tx_overflow <= 1'b0;
    end
  end

  logic unused_bus;
  assign unused_bus = ^{uart_mem_addr_o[DATA_WIDTH-1:4], uart_mem_addr_o[1:0],
                        uart_mem_write_data[DATA_WIDTH-1:16], uart_mem_strobe[3:2]};

endmodule

// File: tb/tb_uart_lite_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_lite_periph
// Directed self-checking bench for uart_lite_periph. Inputs change on the
// falling edge; outputs are sampled on the falling edge. RX scenarios are
// exercised when UART_RX_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_lite_periph;

  localparam logic [31:0] A_TXDATA = 32'h0004_8000;
  localparam logic [31:0] A_RXDATA = 32'h0004_8004;
  localparam logic [31:0] A_STATUS = 32'h0004_8008;
  localparam logic [31:0] A_BAUD   = 32'h0004_800C;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic        read_en;
  logic [3:0]  strobe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        rx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_lite_periph #(
    .DATA_WIDTH       (32),
    .TX_FIFO_DEPTH    (8),
    .DEFAULT_BAUD_DIV (433)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .uart_mem_write_en   (write_en),
    .uart_mem_read_en    (read_en),
    .uart_mem_strobe     (strobe),
    .uart_mem_addr_o     (addr),
    .uart_mem_write_data (wdata),
    .uart_mem_read_data  (rdata),
    .uart_tx             (tx),
    .uart_rx             (rx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; strobe = s; write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0; strobe = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; read_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    read_en = 1'b0;
    d = rdata;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                        output logic [31:0] d);
    addr = a; wdata = wd; strobe = s; write_en = 1'b1; read_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0; strobe = 4'h0;
    d = rdata;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int period);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (period) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * period) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  samples;
    logic [9:0]  frame;
    int          waited;

    rst = 1'b0; write_en = 1'b0; read_en = 1'b0; strobe = 4'h0;
    addr = '0; wdata = '0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_read_data", rdata, 32'h0);
    check("reset_tx_idle", {31'b0, tx}, 32'h1);
    rst = 1'b1;
    @(negedge clk);

    bus_read(A_STATUS, d);
    check("reset_status", d, 32'h0000_0002);
    bus_read(A_BAUD, d);
    check("reset_baud", d, 32'd433);

    // TXDATA write with lane 0 disabled is ignored; TXDATA reads 0
    bus_write(A_TXDATA, 32'h0000_0077, 4'b0010);
    bus_read(A_STATUS, d);
    check("txdata_no_lane0", d, 32'h0000_0002);
    bus_read(A_TXDATA, d);
    check("txdata_read_zero", d, 32'h0);

    // Divider clamp, lane-1-only write, read-before-write ordering
    bus_write(A_BAUD, 32'h0000_0001, 4'b0011);
    bus_read(A_BAUD, d);
    check("baud_clamp", d, 32'd3);
    bus_write(A_BAUD, 32'h0000_01FF, 4'b0010);
    bus_read(A_BAUD, d);
    check("baud_lane1", d, 32'h0000_0103);
    bus_rw(A_BAUD, 32'h0000_0020, 4'b0011, d);
    check("rw_same_cycle_old", d, 32'h0000_0103);
    bus_read(A_BAUD, d);
    check("rw_same_cycle_new", d, 32'h0000_0020);

    // TX frame of 0xA5 at 10 clocks per bit
    bus_write(A_BAUD, 32'd9, 4'b0011);
    bus_read(A_BAUD, d);
    check("baud_9", d, 32'd9);
    bus_write(A_TXDATA, 32'h0000_00A5, 4'b0001);
    waited = 0;
    while (tx !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("tx_start_seen", {31'b0, tx}, 32'h0);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 10; c++) begin
        samples[c] = tx;
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d", b), {22'b0, samples}, frame[b] ? 32'h3FF : 32'h0);
    end
    bus_read(A_STATUS, d);
    check("tx_done_status", d, 32'h0000_0002);

`ifdef UART_RX_EN
    rx_frame(8'h3C, 1'b1, 10);
    bus_read(A_STATUS, d);
    check("rx_valid_set", d, 32'h0000_000A);
    rx_frame(8'h55, 1'b1, 10);
    bus_read(A_STATUS, d);
    check("rx_overrun_set", d, 32'h0000_002A);
    bus_read(A_RXDATA, d);
    check("rx_data_kept", d, 32'h0000_003C);
    bus_read(A_STATUS, d);
    check("rx_valid_clear", d, 32'h0000_0022);
    bus_write(A_STATUS, 32'h0000_0020, 4'b0001);
    bus_read(A_STATUS, d);
    check("rx_overrun_w1c", d, 32'h0000_0002);
    rx_frame(8'h81, 1'b0, 10);
    bus_read(A_STATUS, d);
    check("rx_frame_err", d, 32'h0000_0042);
    bus_write(A_STATUS, 32'h0000_0040, 4'b0001);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_STATUS, d);
    check("rx_glitch_ignored", d, 32'h0000_0002);
    rx_frame(8'hC3, 1'b1, 10);
    bus_read(A_RXDATA, d);
    check("rx_after_glitch", d, 32'h0000_00C3);
`else
    rx_frame(8'h3C, 1'b1, 10);
    bus_read(A_RXDATA, d);
    check("rxdata_absent", d, 32'h0);
    bus_read(A_STATUS, d);
    check("rx_status_absent", d, 32'h0000_0002);
`endif

    // Overflow: first byte goes to the serializer, next 8 fill the FIFO
    bus_write(A_BAUD, 32'h0000_FFFF, 4'b0011);
    for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 32'h10 + i, 4'b0001);
    bus_read(A_STATUS, d);
    check("fifo_full", d, 32'h0000_0805);
    bus_write(A_TXDATA, 32'h0000_00EE, 4'b0001);
    bus_read(A_STATUS, d);
    check("fifo_overflow", d, 32'h0000_0815);
    bus_write(A_STATUS, 32'h0000_0010, 4'b0001);
    bus_read(A_STATUS, d);
    check("overflow_w1c", d, 32'h0000_0805);

    // Reset in the middle of the (very long) start bit
    check("tx_mid_frame_low", {31'b0, tx}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("tx_reset_high", {31'b0, tx}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    bus_read(A_STATUS, d);
    check("reset_fifo_empty", d, 32'h0000_0002);
    bus_read(A_BAUD, d);
    check("reset_baud_again", d, 32'd433);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
